// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, issues one memory read per cycle and buffers
// returning words in a small FIFO presented to decode over valid/ready.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif

module fetch_controller #(
    parameter logic [`ADDR_W-1:0] RESET_PC  = '0,
    parameter int unsigned        BUF_DEPTH = 2,
    parameter int unsigned        PC_STEP   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [`ADDR_W-1:0] o_mem_addr,
    output logic               o_mem_req,
    input  logic [`WORD_W-1:0] i_mem_data,
    input  logic               i_redirect_valid,
    input  logic [`ADDR_W-1:0] i_redirect_addr,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [`WORD_W-1:0] o_instr,
    output logic [`ADDR_W-1:0] o_pc
);

    localparam int unsigned        PtrW   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned        CntW   = PtrW + 1;
    localparam logic [CntW-1:0]    DepthC = CntW'(BUF_DEPTH);
    localparam logic [`ADDR_W-1:0] StepC  = `ADDR_W'(PC_STEP);

    typedef enum logic [1:0] {StIdle, StFetch, StStall} state_e;

    state_e              state_q, state_d;
    logic [`ADDR_W-1:0]  pc_q, pc_d;
    logic [`ADDR_W-1:0]  req_pc_q, req_pc_d;
    logic                inflight_q, inflight_d;
    logic [CntW-1:0]     count_q, count_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [`WORD_W-1:0]  instr_q [BUF_DEPTH];
    logic [`ADDR_W-1:0]  epc_q   [BUF_DEPTH];

    logic                pop;
    logic                push;
    logic                issue;
    logic [CntW:0]       occ;

    // Projected occupancy after this cycle's pop; the in-flight word still needs a slot.
    always_comb begin
        pop   = (count_q != '0) & i_ready;
        push  = inflight_q & ~i_redirect_valid;
        occ   = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q} - {{CntW{1'b0}}, pop};
        issue = (state_q != StIdle) && (occ < {1'b0, DepthC});
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = 1'b0;
        o_mem_req  = 1'b0;
        o_mem_addr = pc_q;
        if (i_redirect_valid) begin
            o_mem_req  = 1'b1;
            o_mem_addr = i_redirect_addr;
            pc_d       = i_redirect_addr + StepC;
            req_pc_d   = i_redirect_addr;
            inflight_d = 1'b1;
            state_d    = StFetch;
        end else begin
            unique case (state_q)
                StIdle: state_d = StFetch;
                StFetch, StStall: begin
                    state_d = issue ? StFetch : StStall;
                    if (issue) begin
                        o_mem_req  = 1'b1;
                        pc_d       = pc_q + StepC;
                        req_pc_d   = pc_q;
                        inflight_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // A redirect drops the returning word and every buffered wrong-path entry.
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (i_redirect_valid) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + {{(CntW-1){1'b0}}, push} - {{(CntW-1){1'b0}}, pop};
        end
    end

    always_comb begin
        o_valid = (count_q != '0);
        o_instr = instr_q[rd_ptr_q];
        o_pc    = epc_q[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                instr_q[i] <= '0;
                epc_q[i]   <= '0;
            end
        end else if (push) begin
            instr_q[wr_ptr_q] <= i_mem_data;
            epc_q[wr_ptr_q]   <= req_pc_q;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count_q == DepthC)));

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: streaming, backpressure, redirects, wrap and async reset.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif

module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] o_mem_addr;
    logic        o_mem_req;
    logic [31:0] i_mem_data = '0;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_addr;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_instr;
    logic [31:0] o_pc;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    always #5 clk = ~clk;

    fetch_controller dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .o_mem_addr       (o_mem_addr),
        .o_mem_req        (o_mem_req),
        .i_mem_data       (i_mem_data),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_addr  (i_redirect_addr),
        .o_valid          (o_valid),
        .i_ready          (i_ready),
        .o_instr          (o_instr),
        .o_pc             (o_pc)
    );

    // Memory contents: addi x(i), x0, i at word index i (0x13, 0x00100093, 0x00200113, ...).
    function automatic logic [31:0] word(input logic [31:0] a);
        logic [31:0] i;
        i = a >> 2;
        return (i << 20) | (i << 7) | 32'h13;
    endfunction

    // One-cycle-latency read port.
    always @(posedge clk) begin
        if (o_mem_req) i_mem_data <= word(o_mem_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic rdy, input logic rv, input logic [31:0] ra);
        @(negedge clk);
        i_ready          = rdy;
        i_redirect_valid = rv;
        i_redirect_addr  = ra;
        #1;
    endtask

    task automatic chk_req(input logic req, input logic [31:0] addr);
        check("mem_req", {31'b0, o_mem_req}, {31'b0, req});
        if (req) check("mem_addr", o_mem_addr, addr);
    endtask

    task automatic chk_out(input logic v, input logic [31:0] pc);
        check("valid", {31'b0, o_valid}, {31'b0, v});
        if (v) begin
            check("pc", o_pc, pc);
            check("instr", o_instr, word(pc));
        end
    endtask

    initial begin
        rst_n            = 1'b1;
        i_ready          = 1'b1;
        i_redirect_valid = 1'b0;
        i_redirect_addr  = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", {31'b0, o_valid}, 32'd0);
        check("rst_req", {31'b0, o_mem_req}, 32'd0);
        check("rst_addr", o_mem_addr, 32'h0);
        check("rst_instr", o_instr, 32'h0);
        check("rst_pc", o_pc, 32'h0);
        repeat (2) @(posedge clk);

        // Release: idle cycle, then sequential fetch 0,4,8...
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_req(1'b0, 32'h0);
        chk_out(1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0); chk_req(1'b1, 32'h0); chk_out(1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0); chk_req(1'b1, 32'h4); chk_out(1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 32'h0);
            chk_req(1'b1, 32'h8 + 32'(4 * i));
            chk_out(1'b1, 32'(4 * i));
        end

        // Backpressure: head frozen at 0xC, no requests.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 32'h0);
            chk_req(1'b0, 32'h0);
            chk_out(1'b1, 32'hC);
        end
        cyc(1'b1, 1'b0, 32'h0); chk_req(1'b1, 32'h14); chk_out(1'b1, 32'hC);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b0, 32'h0);
            chk_req(1'b1, 32'h18 + 32'(4 * i));
            chk_out(1'b1, 32'h10 + 32'(4 * i));
        end

        // Redirect to 0x40 coincident with a pop; in-flight 0x1C dropped.
        cyc(1'b1, 1'b1, 32'h40); chk_req(1'b1, 32'h40); chk_out(1'b1, 32'h18);
        cyc(1'b1, 1'b0, 32'h0);  chk_req(1'b1, 32'h44); chk_out(1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);  chk_req(1'b1, 32'h48); chk_out(1'b1, 32'h40);
        cyc(1'b1, 1'b0, 32'h0);  chk_req(1'b1, 32'h4C); chk_out(1'b1, 32'h44);

        // Back-to-back redirects: 0x200 must never appear, 0x80 stream wins.
        cyc(1'b1, 1'b1, 32'h200); chk_req(1'b1, 32'h200); chk_out(1'b1, 32'h48);
        cyc(1'b1, 1'b1, 32'h80);  chk_req(1'b1, 32'h80);  chk_out(1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);   chk_req(1'b1, 32'h84);  chk_out(1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);   chk_req(1'b1, 32'h88);  chk_out(1'b1, 32'h80);
        cyc(1'b1, 1'b0, 32'h0);   chk_req(1'b1, 32'h8C);  chk_out(1'b1, 32'h84);

        // Redirect with a full FIFO under backpressure.
        cyc(1'b0, 1'b0, 32'h0);  chk_req(1'b0, 32'h0);  chk_out(1'b1, 32'h88);
        cyc(1'b0, 1'b0, 32'h0);  chk_req(1'b0, 32'h0);  chk_out(1'b1, 32'h88);
        cyc(1'b0, 1'b1, 32'h40); chk_req(1'b1, 32'h40); chk_out(1'b1, 32'h88);
        cyc(1'b1, 1'b0, 32'h0);  chk_req(1'b1, 32'h44); chk_out(1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);  chk_req(1'b1, 32'h48); chk_out(1'b1, 32'h40);
        cyc(1'b1, 1'b0, 32'h0);  chk_req(1'b1, 32'h4C); chk_out(1'b1, 32'h44);

        // Address wrap-around.
        cyc(1'b1, 1'b1, 32'hFFFF_FFFC); chk_req(1'b1, 32'hFFFF_FFFC); chk_out(1'b1, 32'h48);
        cyc(1'b1, 1'b0, 32'h0); chk_req(1'b1, 32'h0); chk_out(1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0); chk_req(1'b1, 32'h4); chk_out(1'b1, 32'hFFFF_FFFC);
        cyc(1'b1, 1'b0, 32'h0); chk_req(1'b1, 32'h8); chk_out(1'b1, 32'h0);
        cyc(1'b1, 1'b0, 32'h0); chk_req(1'b1, 32'hC); chk_out(1'b1, 32'h4);

        // Asynchronous reset between clock edges, then restart from RESET_PC.
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", {31'b0, o_valid}, 32'd0);
        check("async_req", {31'b0, o_mem_req}, 32'd0);
        check("async_addr", o_mem_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_req(1'b0, 32'h0);
        chk_out(1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0); chk_req(1'b1, 32'h0); chk_out(1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0); chk_req(1'b1, 32'h4); chk_out(1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0); chk_req(1'b1, 32'h8); chk_out(1'b1, 32'h0);
        cyc(1'b1, 1'b0, 32'h0); chk_req(1'b1, 32'hC); chk_out(1'b1, 32'h4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
